spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
`timescale 1ns/1ps
// SPI mode-0 master sequencing an external 8-bit shift register (load, 8 shifts, readback).
// Latency: DONE lands on cycle 17*CLK_DIV+2, counting the cycle whose edge accepted START as 1.
// Backpressure: none; START is honoured only in IDLE, and requests in any other state are dropped.
module spi_master_ctrl #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       CLR_N,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       MISO,
    input  logic [7:0] SR_Q,
    output logic [7:0] SR_P_DATA,
    output logic       SR_SH_LD,
    output logic       SR_CE,
    output logic       SR_S_DATA,
    output logic       SR_CLR,
    output logic       SCLK,
    output logic       MOSI,
    output logic       CS_N,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RX_DATA
);

    // Each SCLK half-period, and the trailing hold, lasts CLK_DIV core cycles.
    // The phase counter runs 0 .. CLK_DIV-1, which always fits in 8 bits.
    localparam logic [7:0] PHASE_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOW,
        ST_HIGH,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [7:0]  phase_cnt;
    logic        phase_last;
    logic [2:0]  bit_cnt;
    logic        bit_last;     // set once bit_cnt reaches 7, so the counter wrap never adds a 9th shift
    logic        miso_q;       // MISO captured on the first HIGH cycle of the current bit
    logic        miso_bit;     // bit that goes into the shift register on this bit's strobe
    logic [7:0]  p_data;
    logic [7:0]  rx_data;

    assign phase_last = (phase_cnt == PHASE_LAST);

    // With CLK_DIV=1 the sampling cycle and the strobe cycle coincide, so the live pin
    // must feed the shift register directly; otherwise the captured copy is used.
    assign miso_bit = (phase_cnt == 8'd0) ? MISO : miso_q;

    // The slave sees whatever sits in the MSB of the external shift register.
    assign MOSI = SR_Q[7];

    // The shift register is held clear for as long as the controller is in reset.
    assign SR_CLR = ~CLR_N;

    assign SR_P_DATA = p_data;
    assign RX_DATA   = rx_data;

    // State register.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase counter: counts cycles inside LOW, HIGH and HOLD, restarts at 0 on every phase change.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            phase_cnt <= 8'd0;
        end else if (state == ST_LOW || state == ST_HIGH || state == ST_HOLD) begin
            if (phase_last) begin
                phase_cnt <= 8'd0;
            end else begin
                phase_cnt <= phase_cnt + 8'd1;
            end
        end else begin
            phase_cnt <= 8'd0;
        end
    end

    // Bit counter: cleared on load, advanced on every shift strobe; the terminal flag marks bit 7.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            bit_cnt  <= 3'd0;
            bit_last <= 1'b0;
        end else if (state == ST_LOAD) begin
            bit_cnt  <= 3'd0;
            bit_last <= 1'b0;
        end else if (state == ST_HIGH && phase_last) begin
            bit_cnt  <= bit_cnt + 3'd1;
            bit_last <= (bit_cnt == 3'd6);
        end
    end

    // MISO sample taken on the first cycle of each SCLK high phase (the mode-0 rising edge).
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            miso_q <= 1'b0;
        end else if (state == ST_HIGH && phase_cnt == 8'd0) begin
            miso_q <= MISO;
        end
    end

    // Transmit byte latched at acceptance so later TX_DATA changes cannot disturb the transfer.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            p_data <= 8'h00;
        end else if (state == ST_IDLE && START) begin
            p_data <= TX_DATA;
        end
    end

    // Received byte captured on the way into DONE so it is already valid alongside the pulse,
    // then held until the next completion.
    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            rx_data <= 8'h00;
        end else if (state == ST_HOLD && phase_last) begin
            rx_data <= SR_Q;
        end
    end

    // Next-state and Moore outputs; every output idles at its reset level.
    always_comb begin
        state_nxt = state;
        CS_N      = 1'b1;
        SCLK      = 1'b0;
        BUSY      = 1'b0;
        DONE      = 1'b0;
        SR_CE     = 1'b0;
        SR_SH_LD  = 1'b1;
        SR_S_DATA = 1'b0;

        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                CS_N      = 1'b0;
                BUSY      = 1'b1;
                SR_CE     = 1'b1;
                SR_SH_LD  = 1'b0;
                state_nxt = ST_LOW;
            end

            ST_LOW: begin
                CS_N = 1'b0;
                BUSY = 1'b1;
                if (phase_last) begin
                    state_nxt = ST_HIGH;
                end
            end

            ST_HIGH: begin
                CS_N = 1'b0;
                BUSY = 1'b1;
                SCLK = 1'b1;
                // Shift on the last high cycle: MOSI moves to the next bit just before SCLK falls
                // back low, which leaves a full low phase of setup for the slave.
                if (phase_last) begin
                    SR_CE     = 1'b1;
                    SR_S_DATA = miso_bit;
                    state_nxt = bit_last ? ST_HOLD : ST_LOW;
                end
            end

            ST_HOLD: begin
                CS_N = 1'b0;
                BUSY = 1'b1;
                if (phase_last) begin
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                DONE      = 1'b1;
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
`timescale 1ns/1ps
// Bench for spi_master_ctrl: DUT a runs with CLK_DIV=2, DUT b with CLK_DIV=1.
// Each DUT drives a behavioural external shift register; completions are scoreboarded.
// Checks: reset values, timing of DONE, strobe/edge counts, received bytes, abort on reset.
module tb_spi_master_ctrl;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;

    typedef struct packed {
        logic [7:0]  rx;
        logic [31:0] done_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT a (CLK_DIV=2) ----------------
    logic       start_a = 1'b0;
    logic [7:0] tx_data_a = 8'h00;
    logic       miso_a;
    logic [7:0] sr_q_a = 8'h00;
    logic [7:0] sr_p_data_a;
    logic       sr_sh_ld_a, sr_ce_a, sr_s_data_a, sr_clr_a;
    logic       sclk_a, mosi_a, cs_n_a, busy_a, done_a;
    logic [7:0] rx_data_a;
    logic       lb_a = 1'b1;
    logic [7:0] pat_a = 8'hB2;
    int         pat_base_a = 0;
    logic       miso_pat_a = 1'b0;

    assign miso_a = lb_a ? mosi_a : miso_pat_a;

    spi_master_ctrl #(.CLK_DIV(DIV_A)) u_dut_a (
        .CLK(clk), .CLR_N(clr_n), .START(start_a), .TX_DATA(tx_data_a), .MISO(miso_a),
        .SR_Q(sr_q_a), .SR_P_DATA(sr_p_data_a), .SR_SH_LD(sr_sh_ld_a), .SR_CE(sr_ce_a),
        .SR_S_DATA(sr_s_data_a), .SR_CLR(sr_clr_a), .SCLK(sclk_a), .MOSI(mosi_a),
        .CS_N(cs_n_a), .BUSY(busy_a), .DONE(done_a), .RX_DATA(rx_data_a)
    );

    always @(posedge clk or posedge sr_clr_a) begin
        if (sr_clr_a)     sr_q_a <= 8'h00;
        else if (sr_ce_a) sr_q_a <= sr_sh_ld_a ? {sr_q_a[6:0], sr_s_data_a} : sr_p_data_a;
    end

    // ---------------- DUT b (CLK_DIV=1) ----------------
    logic       start_b = 1'b0;
    logic [7:0] tx_data_b = 8'h00;
    logic       miso_b;
    logic [7:0] sr_q_b = 8'h00;
    logic [7:0] sr_p_data_b;
    logic       sr_sh_ld_b, sr_ce_b, sr_s_data_b, sr_clr_b;
    logic       sclk_b, mosi_b, cs_n_b, busy_b, done_b;
    logic [7:0] rx_data_b;
    logic       lb_b = 1'b0;

    assign miso_b = lb_b ? mosi_b : 1'b1;

    spi_master_ctrl #(.CLK_DIV(DIV_B)) u_dut_b (
        .CLK(clk), .CLR_N(clr_n), .START(start_b), .TX_DATA(tx_data_b), .MISO(miso_b),
        .SR_Q(sr_q_b), .SR_P_DATA(sr_p_data_b), .SR_SH_LD(sr_sh_ld_b), .SR_CE(sr_ce_b),
        .SR_S_DATA(sr_s_data_b), .SR_CLR(sr_clr_b), .SCLK(sclk_b), .MOSI(mosi_b),
        .CS_N(cs_n_b), .BUSY(busy_b), .DONE(done_b), .RX_DATA(rx_data_b)
    );

    always @(posedge clk or posedge sr_clr_b) begin
        if (sr_clr_b)     sr_q_b <= 8'h00;
        else if (sr_ce_b) sr_q_b <= sr_sh_ld_b ? {sr_q_b[6:0], sr_s_data_b} : sr_p_data_b;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    exp_t sb_a[$];
    exp_t sb_b[$];

    int   rise_cnt_a = 0, load_cnt_a = 0, shift_cnt_a = 0, csn_low_a = 0, done_cnt_a = 0, ce_bad_a = 0;
    logic sclk_prev_a = 1'b0;
    logic sdat_log_a [256];

    int   rise_cnt_b = 0, load_cnt_b = 0, shift_cnt_b = 0, ones_b = 0, csn_low_b = 0, done_cnt_b = 0, ce_bad_b = 0;
    logic sclk_prev_b = 1'b0;

    // Monitor a: statistics, MISO pattern drive, and scoreboard pop on DONE.
    initial begin
        forever begin
            @(negedge clk);
            if (sclk_a && !sclk_prev_a) rise_cnt_a++;
            if (sr_ce_a && !sr_sh_ld_a) load_cnt_a++;
            if (sr_ce_a && sr_sh_ld_a) begin
                sdat_log_a[shift_cnt_a[7:0]] = sr_s_data_a;
                shift_cnt_a++;
            end
            // A shift strobe belongs only on the second (last) high cycle; a load only in LOAD.
            if (sr_ce_a && (sr_sh_ld_a ? (!sclk_a || !sclk_prev_a) : (cs_n_a || sclk_a))) ce_bad_a++;
            if (!cs_n_a) csn_low_a++;
            if (!sclk_a) miso_pat_a = pat_a[3'(7 - (rise_cnt_a - pat_base_a))];
            sclk_prev_a = sclk_a;
            if (done_a) begin
                done_cnt_a++;
                chk("a_done_expected", sb_a.size() > 0, 1);
                if (sb_a.size() > 0) begin
                    chk("a_rx_data", rx_data_a, sb_a[0].rx);
                    chk("a_done_cycle", cyc, sb_a[0].done_edge);
                    void'(sb_a.pop_front());
                end
            end
        end
    end

    // Monitor b.
    initial begin
        forever begin
            @(negedge clk);
            if (sclk_b && !sclk_prev_b) rise_cnt_b++;
            if (sr_ce_b && !sr_sh_ld_b) load_cnt_b++;
            if (sr_ce_b && sr_sh_ld_b) begin
                shift_cnt_b++;
                if (sr_s_data_b) ones_b++;
            end
            if (sr_ce_b && (sr_sh_ld_b ? !sclk_b : (cs_n_b || sclk_b))) ce_bad_b++;
            if (!cs_n_b) csn_low_b++;
            sclk_prev_b = sclk_b;
            if (done_b) begin
                done_cnt_b++;
                chk("b_done_expected", sb_b.size() > 0, 1);
                if (sb_b.size() > 0) begin
                    chk("b_rx_data", rx_data_b, sb_b[0].rx);
                    chk("b_done_cycle", cyc, sb_b[0].done_edge);
                    void'(sb_b.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle_a();
        int n = 0;
        @(negedge clk);
        while (!(busy_a === 1'b0 && cs_n_a === 1'b1 && done_a === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("a_idle_reached", n < 200, 1);
    endtask

    // mode 0: plain transfer; 1: extra START pulse in the high phase of bit 3;
    // 2: one-cycle reset in the high phase of bit 5 (transfer aborted, nothing expected).
    task automatic xfer_a(input logic [7:0] tx, input logic [7:0] exp_rx, input logic lb, input int mode);
        int b_done, b_load, b_shift, b_rise, b_csn, n;
        wait_idle_a();
        b_done = done_cnt_a; b_load = load_cnt_a; b_shift = shift_cnt_a;
        b_rise = rise_cnt_a; b_csn = csn_low_a;
        lb_a = lb; pat_base_a = rise_cnt_a;
        tx_data_a = tx;
        start_a = 1'b1;
        // Accepting edge is cyc+1; DONE is asserted 17*DIV+1 edges later (cycle 36 for DIV=2).
        if (mode != 2) sb_a.push_back({exp_rx, 32'(cyc + 1 + 17 * DIV_A + 1)});
        @(negedge clk);
        start_a = 1'b0;
        tx_data_a = ~tx;
        chk("a_p_data_capture", sr_p_data_a, tx);
        if (mode != 0) begin
            n = 0;
            while (!((rise_cnt_a - b_rise) == (mode == 1 ? 4 : 6) && sclk_a) && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            chk("a_reach_bit", n < 200, 1);
            if (mode == 1) begin
                start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
            end else begin
                clr_n = 1'b0;
                #1;
                chk("a_rst_cs_n", cs_n_a, 1);
                chk("a_rst_sclk", sclk_a, 0);
                chk("a_rst_sr_clr", sr_clr_a, 1);
                chk("a_rst_busy", busy_a, 0);
                chk("a_rst_done", done_a, 0);
                chk("a_rst_sr_ce", sr_ce_a, 0);
                chk("a_rst_rx_data", rx_data_a, 8'h00);
                chk("a_rst_p_data", sr_p_data_a, 8'h00);
                @(negedge clk);
                clr_n = 1'b1;
                #1;
                chk("a_rst_sr_clr_release", sr_clr_a, 0);
                repeat (60) @(negedge clk);
                #1;
                chk("a_abort_no_done", done_cnt_a - b_done, 0);
                chk("a_abort_idle", busy_a, 0);
                return;
            end
        end
        n = 0;
        while (done_cnt_a == b_done && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("a_done_seen", done_cnt_a - b_done, 1);
        repeat (mode == 1 ? 60 : 3) @(negedge clk);
        #1;
        chk("a_single_done", done_cnt_a - b_done, 1);
        chk("a_load_strobes", load_cnt_a - b_load, 1);
        chk("a_shift_strobes", shift_cnt_a - b_shift, 8);
        chk("a_sclk_rises", rise_cnt_a - b_rise, 8);
        // CS_N low through LOAD (1) + 8 bits of LOW/HIGH (16*DIV) + HOLD (DIV).
        chk("a_cs_low_cycles", csn_low_a - b_csn, 17 * DIV_A + 1);
        chk("a_rx_held", rx_data_a, exp_rx);
        if (!lb) begin
            for (int i = 0; i < 8; i++) chk("a_s_data_seq", sdat_log_a[8'(b_shift + i)], pat_a[7 - i]);
        end
    endtask

    task automatic held_a(input logic [7:0] tx);
        int b_done, b_load, b_shift, n;
        wait_idle_a();
        b_done = done_cnt_a; b_load = load_cnt_a; b_shift = shift_cnt_a;
        lb_a = 1'b1;
        tx_data_a = tx;
        start_a = 1'b1;
        // Acceptances at cycles 1, 38, 75 of the 100-cycle window: DONE at 36, 73, 110.
        for (int k = 0; k < 3; k++) sb_a.push_back({tx, 32'(cyc + 1 + 35 + 37 * k)});
        repeat (100) @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (done_cnt_a - b_done < 3 && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("a_held_done_count", done_cnt_a - b_done, 3);
        chk("a_held_loads", load_cnt_a - b_load, 3);
        chk("a_held_shifts", shift_cnt_a - b_shift, 24);
    endtask

    task automatic xfer_b(input logic [7:0] tx, input logic [7:0] exp_rx, input logic lb, input int exp_ones);
        int b_done, b_load, b_shift, b_rise, b_csn, b_ones, n;
        n = 0;
        @(negedge clk);
        while (!(busy_b === 1'b0 && cs_n_b === 1'b1 && done_b === 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b_idle_reached", n < 200, 1);
        b_done = done_cnt_b; b_load = load_cnt_b; b_shift = shift_cnt_b;
        b_rise = rise_cnt_b; b_csn = csn_low_b; b_ones = ones_b;
        lb_b = lb;
        tx_data_b = tx;
        start_b = 1'b1;
        // DIV=1: DONE asserted 18 edges after acceptance (cycle 19).
        sb_b.push_back({exp_rx, 32'(cyc + 1 + 17 * DIV_B + 1)});
        @(negedge clk);
        start_b = 1'b0;
        tx_data_b = ~tx;
        n = 0;
        while (done_cnt_b == b_done && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("b_single_done", done_cnt_b - b_done, 1);
        chk("b_load_strobes", load_cnt_b - b_load, 1);
        chk("b_shift_strobes", shift_cnt_b - b_shift, 8);
        chk("b_sclk_rises", rise_cnt_b - b_rise, 8);
        chk("b_cs_low_cycles", csn_low_b - b_csn, 17 * DIV_B + 1);
        chk("b_s_data_ones", ones_b - b_ones, exp_ones);
    endtask

    initial begin
        #2;
        clr_n = 1'b0;
        #1;
        chk("reset_cs_n", cs_n_a, 1);
        chk("reset_sclk", sclk_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_sr_ce", sr_ce_a, 0);
        chk("reset_sr_sh_ld", sr_sh_ld_a, 1);
        chk("reset_p_data", sr_p_data_a, 8'h00);
        chk("reset_rx_data", rx_data_a, 8'h00);
        chk("reset_sr_clr", sr_clr_a, 1);
        chk("reset_b_cs_n", cs_n_b, 1);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        #1;
        chk("release_sr_clr", sr_clr_a, 0);

        xfer_a(8'hA5, 8'hA5, 1'b1, 0);      // loopback returns the byte rotated 8 times
        xfer_b(8'h12, 8'hFF, 1'b0, 8);      // MISO held high fills the register with ones
        xfer_b(8'h96, 8'h96, 1'b1, 4);      // DIV=1 loopback: same-cycle sample and shift
        xfer_a(8'h7E, 8'hB2, 1'b0, 0);      // MISO 1,0,1,1,0,0,1,0
        xfer_a(8'h5A, 8'h5A, 1'b1, 1);      // stray START mid-transfer
        xfer_a(8'hC3, 8'h00, 1'b1, 2);      // reset during bit 5
        xfer_a(8'h81, 8'h81, 1'b1, 0);      // first transfer after reset
        held_a(8'h3C);                      // START held high

        chk("a_scoreboard_empty", sb_a.size(), 0);
        chk("b_scoreboard_empty", sb_b.size(), 0);
        chk("a_stray_strobes", ce_bad_a, 0);
        chk("b_stray_strobes", ce_bad_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
